// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the FP add/sub datapath: default widths, clog2 and
// a priority leading-zero counter used by the normalisation pipeline.
package fp_addsub_pkg;

    localparam int MAN_W_DEF = 23;
    localparam int GRD_W_DEF = 8;
    localparam int LZC_MAX_W = 64;
    localparam int LZC_CNT_W = 7;

    typedef struct packed {
        logic [LZC_CNT_W-1:0] lz;
        logic                 zero;
    } lzc_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Leading zeros counted from bit w-1; the highest set bit wins, zero input gives lz=0
    function automatic lzc_t lzc(input logic [LZC_MAX_W-1:0] sum, input int w);
        lzc_t res;
        logic found;
        res.lz   = '0;
        res.zero = 1'b1;
        found    = 1'b0;
        for (int i = LZC_MAX_W - 1; i >= 0; i--) begin
            if ((i < w) && !found && sum[i]) begin
                found    = 1'b1;
                res.zero = 1'b0;
                res.lz   = LZC_CNT_W'(w - 1 - i);
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_norm_shifter.sv
// Logarithmic left barrel shifter with zero fill, one level per shift-amount bit.
module fp_norm_shifter #(
    parameter int SUM_W = 33,
    parameter int SH_W  = 6
) (
    input  logic [SUM_W-1:0] data,
    input  logic [SH_W-1:0]  shift,
    output logic [SUM_W-1:0] result
);

    logic [SUM_W-1:0] lvl_s;

    // Each level conditionally shifts by a power of two
    always_comb begin
        lvl_s = data;
        for (int i = 0; i < SH_W; i++) begin
            if (shift[i]) begin
                lvl_s = lvl_s << (32'd1 << i);
            end else begin
                lvl_s = lvl_s;
            end
        end
        result = lvl_s;
    end

endmodule

// File: rtl/fp_addsub_norm_pipe.sv
// Three-stage valid/ready pipeline: mantissa add/sub, leading-zero detect,
// full normalising left shift. Sits between exponent align and round/pack.
module fp_addsub_norm_pipe
    import fp_addsub_pkg::*;
#(
    parameter int MAN_W = MAN_W_DEF,
    parameter int GRD_W = GRD_W_DEF,
    parameter int SUM_W = MAN_W + GRD_W + 2,
    parameter int SH_W  = clog2(SUM_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] in_mmax,
    input  logic [MAN_W:0]   in_mmin,
    input  logic             in_sa,
    input  logic             in_sb,
    input  logic             in_maxab,
    input  logic             in_opmode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [SH_W-1:0]  out_shift,
    output logic             out_psgn,
    output logic             out_opr,
    output logic             out_zero
);

    logic             ld1_s, ld2_s, ld3_s;
    logic             v1_r, v2_r;
    logic [SUM_W-1:0] a_s, b_s, sum_s;
    logic             opr_s, psgn_s;
    logic [SUM_W-1:0] s1_sum_r;
    logic             s1_opr_r, s1_psgn_r;
    lzc_t             lzc_s;
    logic             lz_unused_s;
    logic [SUM_W-1:0] s2_sum_r;
    logic [SH_W-1:0]  s2_lz_r;
    logic             s2_zero_r, s2_opr_r, s2_psgn_r;
    logic [SUM_W-1:0] shifted_s;

    // Stage k loads when empty or when stage k+1 loads this cycle
    always_comb begin
        ld3_s    = ~out_valid | out_ready;
        ld2_s    = ~v2_r | ld3_s;
        ld1_s    = ~v1_r | ld2_s;
        in_ready = rst_n & ld1_s;
    end

    // Effective operation, result sign and raw aligned sum (B<=A guaranteed upstream)
    always_comb begin
        opr_s  = in_opmode ^ in_sa ^ in_sb;
        psgn_s = in_maxab ? in_sb : in_sa;
        a_s    = {1'b0, 1'b1, in_mmax, {GRD_W{1'b0}}};
        b_s    = {1'b0, in_mmin, {GRD_W{1'b0}}};
        if (opr_s) begin
            sum_s = a_s - b_s;
        end else begin
            sum_s = a_s + b_s;
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            s1_sum_r  <= '0;
            s1_opr_r  <= 1'b0;
            s1_psgn_r <= 1'b0;
        end else if (ld1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_sum_r  <= sum_s;
                s1_opr_r  <= opr_s;
                s1_psgn_r <= psgn_s;
            end
        end
    end

    // Leading-zero detect on the stage-1 sum
    always_comb begin
        lzc_s       = lzc(LZC_MAX_W'(s1_sum_r), SUM_W);
        lz_unused_s = ^lzc_s.lz;
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r      <= 1'b0;
            s2_sum_r  <= '0;
            s2_lz_r   <= '0;
            s2_zero_r <= 1'b0;
            s2_opr_r  <= 1'b0;
            s2_psgn_r <= 1'b0;
        end else if (ld2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                s2_sum_r  <= s1_sum_r;
                s2_lz_r   <= SH_W'(lzc_s.lz);
                s2_zero_r <= lzc_s.zero;
                s2_opr_r  <= s1_opr_r;
                s2_psgn_r <= s1_psgn_r;
            end
        end
    end

    fp_norm_shifter #(
        .SUM_W(SUM_W),
        .SH_W (SH_W)
    ) u_shifter (
        .data  (s2_sum_r),
        .shift (s2_lz_r),
        .result(shifted_s)
    );

    // Stage 3 output register; an exact zero is reported as +0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_shift <= '0;
            out_psgn  <= 1'b0;
            out_opr   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (ld3_s) begin
            out_valid <= v2_r;
            if (v2_r) begin
                out_sum   <= shifted_s;
                out_shift <= s2_lz_r;
                out_psgn  <= s2_psgn_r & ~s2_zero_r;
                out_opr   <= s2_opr_r;
                out_zero  <= s2_zero_r;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_norm_pipe.sv
// Self-checking bench for fp_addsub_norm_pipe: directed vectors with fixed
// expectations, plus random streams against an arithmetic reference model.
module tb_fp_addsub_norm_pipe;

    localparam int MAN_W = 23;
    localparam int GRD_W = 8;
    localparam int SUM_W = MAN_W + GRD_W + 2;
    localparam int SH_W  = 6;

    typedef struct {
        logic [MAN_W-1:0] mmax;
        logic [MAN_W:0]   mmin;
        logic             sa, sb, maxab, op;
    } beat_t;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [SH_W-1:0]  shift;
        logic             psgn;
        logic             opr;
        logic             zero;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [MAN_W-1:0] in_mmax = '0;
    logic [MAN_W:0]   in_mmin = '0;
    logic             in_sa = 1'b0, in_sb = 1'b0, in_maxab = 1'b0, in_opmode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] out_sum;
    logic [SH_W-1:0]  out_shift;
    logic             out_psgn, out_opr, out_zero;

    int checks = 0;
    int errors = 0;

    fp_addsub_norm_pipe #(.MAN_W(MAN_W), .GRD_W(GRD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mmax(in_mmax), .in_mmin(in_mmin),
        .in_sa(in_sa), .in_sb(in_sb), .in_maxab(in_maxab), .in_opmode(in_opmode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_shift(out_shift),
        .out_psgn(out_psgn), .out_opr(out_opr), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    // Reference: real-valued mantissa arithmetic, then shift up until the top bit is one
    function automatic exp_t model(input beat_t b);
        exp_t e;
        longint unsigned a, m, s;
        int sh;
        logic opr;
        opr = b.op ^ b.sa ^ b.sb;
        a = (64'd1 << (MAN_W + GRD_W)) + (64'(b.mmax) << GRD_W);
        m = 64'(b.mmin) << GRD_W;
        s = opr ? a - m : a + m;
        e.opr = opr;
        if (s == 64'd0) begin
            e.sum = '0; e.shift = '0; e.zero = 1'b1; e.psgn = 1'b0;
        end else begin
            sh = 0;
            while (s < (64'd1 << (SUM_W - 1))) begin
                s = s << 1;
                sh++;
            end
            e.sum = SUM_W'(s); e.shift = SH_W'(sh); e.zero = 1'b0;
            e.psgn = b.maxab ? b.sb : b.sa;
        end
        return e;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int unsigned bound;
        b.mmax = MAN_W'($urandom);
        bound = {1'b1, b.mmax};
        case ($urandom_range(0, 2))
            0: b.mmin = (MAN_W+1)'($urandom_range(0, bound));
            1: b.mmin = (MAN_W+1)'(bound - $urandom_range(0, 300));
            default: b.mmin = (MAN_W+1)'($urandom_range(0, 4095));
        endcase
        b.sa = 1'($urandom); b.sb = 1'($urandom);
        b.maxab = 1'($urandom); b.op = 1'($urandom);
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_mmax = b.mmax; in_mmin = b.mmin;
        in_sa = b.sa; in_sb = b.sb; in_maxab = b.maxab; in_opmode = b.op;
    endtask

    function automatic exp_t observe();
        exp_t o;
        o = {out_sum, out_shift, out_psgn, out_opr, out_zero};
        return o;
    endfunction

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got valid/ready=%b%b, want 00", out_valid, in_ready);
        end
        checks++;
        if (observe() !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, want 0", observe());
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        beat_t v[9];
        exp_t  e[9];
        exp_t  o;
        v[0] = '{23'h000000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0};
        e[0] = {33'h1_0000_0000, 6'd0, 1'b0, 1'b0, 1'b0};
        v[1] = '{23'h400000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b1};
        e[1] = {33'h1_0000_0000, 6'd2, 1'b0, 1'b1, 1'b0};
        v[2] = '{23'h000001, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b1};
        e[2] = {33'h1_0000_0000, 6'd24, 1'b0, 1'b1, 1'b0};
        v[3] = '{23'h000000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b1};
        e[3] = {33'h0, 6'd0, 1'b0, 1'b1, 1'b1};
        v[4] = '{23'h000000, 24'h800000, 1'b1, 1'b1, 1'b0, 1'b1};
        e[4] = {33'h0, 6'd0, 1'b0, 1'b1, 1'b1};
        v[5] = '{23'h400000, 24'h800000, 1'b1, 1'b0, 1'b1, 1'b0};
        e[5] = {33'h1_0000_0000, 6'd2, 1'b0, 1'b1, 1'b0};
        v[6] = '{23'h400000, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0};
        e[6] = {33'h1_0000_0000, 6'd2, 1'b1, 1'b1, 1'b0};
        v[7] = '{23'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        e[7] = {33'h1_FFFF_FE00, 6'd0, 1'b0, 1'b0, 1'b0};
        v[8] = '{23'h000000, 24'h000001, 1'b1, 1'b1, 1'b1, 1'b0};
        e[8] = {33'h1_0000_0200, 6'd1, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(v[i]); in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_in_ready[%0d]: got %b, want 1", i, in_ready);
            end
            @(posedge clk); #1; in_valid = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== (k == 3)) begin
                    errors++;
                    $display("FAIL dir_latency[%0d] cycle %0d: got valid=%b, want %b", i, k, out_valid, k == 3);
                end
                if (k < 3) begin
                    @(posedge clk); #1;
                end
            end
            o = observe();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL dir_data[%0d]: got sum=%h sh=%0d ps=%b op=%b z=%b, want sum=%h sh=%0d ps=%b op=%b z=%b",
                         i, o.sum, o.shift, o.psgn, o.opr, o.zero, e[i].sum, e[i].shift, e[i].psgn, e[i].opr, e[i].zero);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        beat_t b[12];
        exp_t  q[$];
        exp_t  o, x;
        for (int i = 0; i < 12; i++) b[i] = rand_beat();
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            in_valid = (j < 12);
            if (j < 12) drive(b[j]);
            @(negedge clk);
            checks++;
            if (out_valid !== (j >= 3 && j < 15)) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: got %b, want %b", j, out_valid, (j >= 3 && j < 15));
            end
            if (j < 12) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b, want 1", j, in_ready);
                end
            end
            if (out_valid && q.size() > 0) begin
                x = q.pop_front();
                o = observe();
                checks++;
                if (o !== x) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h, want %h", j, o, x);
                end
            end
            if (j < 12 && in_ready) q.push_back(model(b[j]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        beat_t b[8];
        exp_t  q[$];
        exp_t  o, x, prev_o;
        int    acc, drn, cyc;
        logic  prev_stall;
        for (int i = 0; i < 8; i++) b[i] = rand_beat();
        acc = 0; drn = 0; cyc = 0; prev_stall = 1'b0; prev_o = '0;
        while (drn < 8 && cyc < 300) begin
            out_ready = 1'($urandom);
            in_valid  = (acc < 8);
            if (acc < 8) drive(b[acc]);
            @(negedge clk);
            o = observe();
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || o !== prev_o) begin
                    errors++;
                    $display("FAIL bp_stall_stable[%0d]: got valid=%b %h, want valid=1 %h", cyc, out_valid, o, prev_o);
                end
            end
            checks++;
            if (in_ready !== !((acc - drn) == 3 && !out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b, want %b (in flight %0d)", cyc, in_ready, !((acc - drn) == 3 && !out_ready), acc - drn);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_beat[%0d]: got %h, want no beat", cyc, o);
                end else begin
                    x = q.pop_front();
                    if (o !== x) begin
                        errors++;
                        $display("FAIL bp_data[%0d]: got %h, want %h", drn, o, x);
                    end
                end
                drn++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(b[acc]));
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_o = o;
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (drn != 8) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d, want 8", drn);
        end
    endtask

    task automatic test_reset_midstream();
        beat_t b;
        exp_t  o, x;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(rand_beat()); in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_fill_ready[%0d]: got %b, want 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_full: got valid/ready=%b%b, want 10", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00 || observe() !== '0) begin
            errors++;
            $display("FAIL rst_async: got valid/ready=%b%b data=%h, want 00 data=0", out_valid, in_ready, observe());
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        b = rand_beat();
        x = model(b);
        drive(b); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_post_ready: got %b, want 1", in_ready);
        end
        @(posedge clk); #1; in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL rst_post_valid cycle %0d: got %b, want %b", k, out_valid, k == 3);
            end
            if (k == 3) begin
                o = observe();
                checks++;
                if (o !== x) begin
                    errors++;
                    $display("FAIL rst_post_data: got %h, want %h", o, x);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_addsub_norm_pipe.md
Name: fp_addsub_norm_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle FP32 mantissa add/sub + normalisation-shift slice.
- Performs the effective add/sub of aligned mantissas, resolves sign and effective operation, counts leading zeros, and fully normalises the result (arbitrary left shift, not just a 16|0 coarse step).
- Three-stage valid/ready pipeline. Sits between the exponent-align stage and the round/pack stage of the FP add/sub unit.

Parameters:
- MAN_W, 23, stored mantissa width (hidden bit excluded).
- GRD_W, 8, guard/extension zeros appended below the mantissa.
- SUM_W, MAN_W+GRD_W+2, derived: sum width including carry-out bit.
- SH_W, $clog2(SUM_W), derived: shift-amount width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline can accept a beat
- in_mmax  in  MAN_W  larger mantissa (hidden 1 implied)
- in_mmin  in  MAN_W+1  smaller mantissa, aligned, hidden bit explicit
- in_sa  in  1  sign of A
- in_sb  in  1  sign of B
- in_maxab  in  1  larger operand (0=A, 1=B)
- in_opmode  in  1  requested op (0=add, 1=sub)
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_sum  out  SUM_W  normalised sum; MSB=1 unless zero
- out_shift  out  SH_W  left-shift applied (leading-zero count from bit SUM_W-1)
- out_psgn  out  1  result sign
- out_opr  out  1  effective operation (1=subtract)
- out_zero  out  1  exact-zero result

Behaviour:
- Reset is asynchronous, active-low; clk is the only clock. While rst_n=0:
  - all stage valid flags, out_valid and every out_* data register = 0;
  - in_ready = 0.
  - Reset asserted mid-operation discards all in-flight beats. First accept is possible on the first rising edge after release.
- Handshake:
  - A beat transfers on in_valid&in_ready at a rising edge; output completes on out_valid&out_ready.
  - Per-stage rule: stage k may load when its valid is 0 or stage k+1 loads this cycle. in_ready = stage-1 may load (combinational from out_ready through the chain; no combinational in_valid->out_valid path).
  - Latency is exactly 3 cycles with no backpressure. Throughput is 1 beat/cycle with out_ready held high.
  - out_* holds stable while out_valid=1 and out_ready=0. No beat is lost or duplicated.
- Stage 1 (add/sub):
  - opr = in_opmode^in_sa^in_sb; psgn = in_maxab ? in_sb : in_sa.
  - A = {1, in_mmax, GRD_W zeros}, B = {in_mmin, GRD_W zeros}, both zero-extended to SUM_W.
  - sum = opr ? A-B : A+B, computed in SUM_W bits. B<=A is guaranteed by upstream, so there is no negative result.
- Stage 2 (LZD): lz = leading zeros of sum from bit SUM_W-1.
  - sum==0 -> zero=1, lz=0.
  - Encoding is priority-based, so the highest set bit wins.
- Stage 3 (normalise): out_sum = sum << lz (logarithmic barrel shift, SH_W levels, zero fill); out_shift = lz.
  - For zero: out_sum=0, out_shift=0, out_zero=1, out_psgn=0 (+0 for x-x), out_opr passed through.
- Boundaries:
  - Add carry-out sets bit SUM_W-1 -> shift 0.
  - Maximum shift for nonzero data is SUM_W-1-GRD_W (leading one at bit GRD_W).
  - A simultaneous output drain and input accept while the pipe is full must advance all stages in the same cycle.

Decomposition:
- Shared package fp_addsub_pkg: default MAN_W/GRD_W, function clog2, function lzc(sum) returning lz and zero.
- One natural sub-module, fp_norm_shifter (parametrised SUM_W/SH_W barrel left shifter), instantiated in stage 3.
- Adder kept as a plain behavioural +/- so synthesis maps it.

Test Plan (MAN_W=23, GRD_W=8):
- 1.0+1.0: mmax=0, mmin=24'h800000, opmode=0, sa=sb=0 -> after 3 cycles out_sum=33'h1_0000_0000, shift=0, opr=0, zero=0.
- 1.5-1.0: mmax=23'h400000, mmin=24'h800000, opmode=1 -> raw sum 33'h0_4000_0000, out_shift=2, out_sum=33'h1_0000_0000, opr=1.
- Minimum difference: mmax=23'h000001, mmin=24'h800000, opmode=1 -> raw sum 33'h100, out_shift=24, out_sum=33'h1_0000_0000. Also x-x (mmax=0, mmin=24'h800000, sub) -> out_zero=1, out_sum=0, out_psgn=0.
- Sign resolve: sa=1, sb=0, maxab=1, opmode=0 -> opr=1, psgn=0. The same inputs with maxab=0 -> psgn=1.
- Backpressure: stream 8 random beats with out_ready toggling 1/0 randomly -> outputs in order, bit-exact against the reference model, stable while stalled, in_ready=0 only when the pipe is full and out_ready=0.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (async). After release, a new beat emerges 3 cycles after accept and no stale beats appear.
